// File: rtl/mem_addr_seq.sv
// mem_addr_seq: registered memory-address source mux with exception vector fetch.
// Normal cycles forward src_addr[sel]; an exception drives VEC_BASE+vec and captures the handler byte.
module mem_addr_seq #(
    parameter int          WIDTH    = 32,
    parameter int          NUM_SRC  = 5,
    parameter int          SEL_W    = 3,
    parameter int unsigned VEC_BASE = 253,
    parameter int          NUM_VEC  = 3,
    parameter int          MEM_LAT  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_addr,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     exc_req,
    input  logic [1:0]               exc_code,
    input  logic [7:0]               mem_rdata,
    output logic [WIDTH-1:0]         mem_addr,
    output logic                     sel_err,
    output logic                     exc_busy,
    output logic                     exc_done,
    output logic [WIDTH-1:0]         handler_pc
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d, vec_req;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d, handler_pc_q, handler_pc_d, src_mux;
    logic             sel_err_q, sel_err_d, exc_busy_q, exc_busy_d, exc_done_q, exc_done_d;
    logic             sel_ok;

    always_comb begin
        src_mux = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (32'(sel) == 32'(i)) src_mux = src_addr[i*WIDTH +: WIDTH];
    end

    assign sel_ok  = 32'(sel) < 32'(NUM_SRC);
    assign vec_req = (32'(exc_code) < 32'(NUM_VEC)) ? exc_code : 2'(NUM_VEC - 1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        mem_addr_d   = mem_addr_q;
        handler_pc_d = handler_pc_q;
        sel_err_d    = sel_err_q;
        exc_busy_d   = exc_busy_q;
        exc_done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (exc_req) begin
                vec_d      = vec_req;
                mem_addr_d = WIDTH'(VEC_BASE) + WIDTH'(vec_req);
                cnt_d      = CNT_W'(MEM_LAT);
                exc_busy_d = 1'b1;
                state_d    = WAIT;
            end else begin
                mem_addr_d = sel_ok ? src_mux : '0;
                sel_err_d  = !sel_ok;
            end
        end else begin
            // vector address is held while the memory answers
            mem_addr_d = WIDTH'(VEC_BASE) + WIDTH'(vec_q);
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                handler_pc_d = {{(WIDTH-8){1'b0}}, mem_rdata};
                exc_done_d   = 1'b1;
                exc_busy_d   = 1'b0;
                state_d      = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            vec_q        <= '0;
            mem_addr_q   <= '0;
            handler_pc_q <= '0;
            sel_err_q    <= 1'b0;
            exc_busy_q   <= 1'b0;
            exc_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            mem_addr_q   <= mem_addr_d;
            handler_pc_q <= handler_pc_d;
            sel_err_q    <= sel_err_d;
            exc_busy_q   <= exc_busy_d;
            exc_done_q   <= exc_done_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign sel_err    = sel_err_q;
    assign exc_busy   = exc_busy_q;
    assign exc_done   = exc_done_q;
    assign handler_pc = handler_pc_q;
endmodule

// File: doc/mem_addr_seq.md
Name: mem_addr_seq

Overview:
- Parametrised successor to the memory-address source mux of the multicycle MIPS datapath.
- Selects one of NUM_SRC address sources and drives a registered memory address.
- Owns exception vector fetch: on an exception request it drives the vector address, waits out memory latency, captures the vector byte and presents the handler PC with a done pulse.
- Sits between the control unit / PC logic and the memory address port.

Parameters:
- WIDTH, 32, address/data width of sources, mem_addr and handler_pc.
- NUM_SRC, 5, number of normal address sources (2..8).
- SEL_W, 3, width of sel; 2**SEL_W >= NUM_SRC.
- VEC_BASE, 253, address of vector 0; vector k lives at VEC_BASE+k.
- NUM_VEC, 3, number of exception vectors (1..4).
- MEM_LAT, 1, cycles from mem_addr registered to mem_rdata valid (>=1).

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- src_addr, input, NUM_SRC*WIDTH, flat source bus; source i = bits [i*WIDTH +: WIDTH].
- sel, input, SEL_W, source select.
- exc_req, input, 1, exception request, sampled in IDLE only.
- exc_code, input, 2, vector index.
- mem_rdata, input, 8, memory read byte.
- mem_addr, output, WIDTH, registered memory address.
- sel_err, output, 1, registered; high when the last sampled sel >= NUM_SRC.
- exc_busy, output, 1, vector fetch in progress.
- exc_done, output, 1, one-cycle pulse when handler_pc is updated.
- handler_pc, output, WIDTH, zero-extended vector byte.

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE.
  - mem_addr, handler_pc, the latency counter and the latched vector are 0.
  - sel_err, exc_busy and exc_done are 0.
  - Reset takes effect immediately mid-fetch; no capture occurs.
- IDLE, exc_req=0:
  - Each edge: mem_addr <= src_addr[sel] if sel < NUM_SRC.
  - Otherwise mem_addr <= 0 and sel_err <= 1.
  - sel_err <= 0 on any valid sel.
  - Latency is 1 cycle.
- IDLE, exc_req=1:
  - exc_req has priority over sel.
  - vec = exc_code if exc_code < NUM_VEC, else NUM_VEC-1 (clamped).
  - mem_addr <= VEC_BASE+vec. sel_err holds its value.
  - exc_busy <= 1; counter <= MEM_LAT; go to WAIT.
- WAIT:
  - mem_addr is held; sel is ignored; exc_req is ignored (no queuing).
  - Counter decrements each edge.
  - On the edge where the counter equals 1:
    - handler_pc <= {zeros, mem_rdata}.
    - exc_done <= 1; exc_busy <= 0; go to IDLE.
  - mem_rdata is sampled exactly MEM_LAT edges after mem_addr took the vector address.
- exc_done:
  - High for exactly one cycle.
  - Cleared on the next edge regardless of state.
- After return to IDLE:
  - The next edge resumes source muxing.
  - If exc_req is high on that edge, a new fetch starts (back-to-back allowed).
- Total timing: exc_req sampled at edge E0; exc_done/handler_pc visible after edge E0+MEM_LAT; exc_busy high from E0 until E0+MEM_LAT.
- handler_pc holds its value until the next capture or reset.
- Width: the VEC_BASE+vec sum is truncated to WIDTH. The vector byte is zero-extended, never sign-extended.

Test Plan:
- Reset then mux: reset_n low with sources 0x100/0x200/0x300/0x400/0x500; release and set sel=2 -> after 1 edge mem_addr=0x300, sel_err=0. Then sel=4 -> 0x500.
- Invalid select: sel=6 -> next edge mem_addr=0, sel_err=1. Then sel=0 -> mem_addr=0x100, sel_err=0.
- Vector fetch, MEM_LAT=1: exc_req=1, exc_code=1, sel=3 in IDLE -> mem_addr=254 (not 0x400), exc_busy=1. Memory returns 0x8C -> next edge handler_pc=0x0000008C, exc_done pulses 1 cycle, exc_busy=0. Following edge mem_addr=src[sel].
- Clamp and latency, MEM_LAT=3: exc_code=3 -> mem_addr=255, held 3 cycles. exc_req re-pulsed and sel toggled during WAIT -> ignored. handler_pc=mem_rdata at the third edge; single exc_done.
- Reset mid-fetch: assert reset_n low during WAIT -> mem_addr=0, exc_busy=0, handler_pc=0 immediately. No exc_done after release.
- Back-to-back: exc_req held high -> two fetches; second mem_addr=VEC_BASE+code issued on the edge after the first exc_done. Two exc_done pulses separated by MEM_LAT+1 cycles.
